// File: rtl/gf_inv_128.sv
// Sequential GF(2^128) inverter: a^-1 = a^(2^128-2) by square-and-multiply,
// time-sharing one combinational gf_mul_128 (GHASH bit order, x^128+x^7+x^2+x+1).

module gf_mul_128 (
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [127:0] y
);
  logic [127:0] ar;
  logic [127:0] br;
  logic [127:0] pr;
  logic [254:0] prod;

  // bit 127 of a/b/y is the x^0 coefficient; work in natural order internally
  always_comb begin
    ar   = '0;
    br   = '0;
    pr   = '0;
    y    = '0;
    prod = '0;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    for (int i = 0; i < 128; i++) begin
      if (br[i]) prod = prod ^ ({127'd0, ar} << i);
    end
    for (int i = 254; i >= 128; i--) begin
      if (prod[i]) begin
        prod[i]     = 1'b0;
        prod[i-121] = ~prod[i-121];
        prod[i-126] = ~prod[i-126];
        prod[i-127] = ~prod[i-127];
        prod[i-128] = ~prod[i-128];
      end
    end
    pr = prod[127:0];
    for (int i = 0; i < 128; i++) y[i] = pr[127-i];
  end
endmodule

module gf_inv_128 #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_inv,
  output logic         out_zero,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  localparam logic [127:0] ONE = {1'b1, 127'd0};

  state_t       state;
  state_t       state_nxt;
  logic [127:0] sq;
  logic [127:0] res;
  logic [6:0]   cnt;
  logic         zero_flag;
  logic [127:0] mul_a;
  logic [127:0] mul_y;
  logic         accept;
  logic         a_zero;

  assign accept = in_valid && (state == IDLE);
  assign a_zero = (in_a == '0);
  assign mul_a  = (state == MUL) ? res : sq;

  gf_mul_128 u_mul (
    .a (mul_a),
    .b (sq),
    .y (mul_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (SKIP_ZERO && a_zero) ? DONE : SQR;
      SQR:  state_nxt = MUL;
      MUL:  state_nxt = (cnt == 7'd127) ? DONE : SQR;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // res holds a^(2^(k+1)-2) after the k-th MUL; cnt stops at 127
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq        <= '0;
      res       <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
    end else if (accept) begin
      sq        <= in_a;
      res       <= (SKIP_ZERO && a_zero) ? '0 : ONE;
      cnt       <= '0;
      zero_flag <= a_zero;
    end else if (state == SQR) begin
      sq        <= mul_y;
      cnt       <= cnt + 7'd1;
    end else if (state == MUL) begin
      res       <= mul_y;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_inv   = (state == DONE) ? res : '0;
    out_zero  = (state == DONE) && zero_flag;
  end
endmodule

// File: tb/tb_gf_inv_128.sv
// Directed bench for gf_inv_128: known inverses of small powers of x, zero
// handling for both SKIP_ZERO settings, backpressure, busy hold-off and reset abort.

module tb_gf_inv_128;
  localparam logic [127:0] ONE  = {1'b1, 127'd0};
  localparam logic [127:0] X1   = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] X1I  = 128'hC200_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] X2   = 128'h2000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] X2I  = 128'h4600_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] X3   = 128'h1000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] X3I  = 128'h8C00_0000_0000_0000_0000_0000_0000_0006;

  logic         clk;
  logic         rst_n;
  logic [1:0]   iv, ir, ov, ordy, oz, bz;
  logic [127:0] ia [2];
  logic [127:0] oi [2];
  int           n_checks;
  int           n_errors;

  gf_inv_128 #(.SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_inv(oi[0]), .out_zero(oz[0]), .busy(bz[0])
  );

  gf_inv_128 #(.SKIP_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_inv(oi[1]), .out_zero(oz[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference GHASH multiply (shift-right formulation, R = 0xE1 || 0^120)
  function automatic logic [127:0] ref_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ 128'hE100_0000_0000_0000_0000_0000_0000_0000) : (v >> 1);
    end
    return z;
  endfunction

  // latency counts the accept edge as cycle 1
  task automatic run_op(input int s, input logic [127:0] a,
                        output logic [127:0] inv, output logic zero, output int lat);
    iv[s] = 1'b1;
    ia[s] = a;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      iv[s] = 1'b0;
    end while (!ov[s] && lat < 400);
    if (!ov[s]) chk("timeout", {127'd0, ov[s]}, 128'd1);
    inv     = oi[s];
    zero    = oz[s];
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
  endtask

  initial begin
    logic [127:0] inv, inv2, a, held;
    logic         zero, bad;
    int           lat, n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    ia[0] = '0;
    ia[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {127'd0, ir[0]}, 128'd1);
    chk("rst_out_valid", {127'd0, ov[0]}, 128'd0);
    chk("rst_out_inv",   oi[0], '0);
    chk("rst_out_zero",  {127'd0, oz[0]}, 128'd0);
    chk("rst_busy",      {127'd0, bz[0]}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, ONE, inv, zero, lat);
    chk("one_inv", inv, ONE);
    chk("one_zero", {127'd0, zero}, 128'd0);
    chk("one_lat", 128'(lat), 128'd255);
    chk("one_ready_after", {127'd0, ir[0]}, 128'd1);

    run_op(0, X1, inv, zero, lat);
    chk("x_inv", inv, X1I);
    run_op(0, X1I, inv, zero, lat);
    chk("xinv_inv", inv, X1);
    run_op(0, X2, inv, zero, lat);
    chk("x2_inv", inv, X2I);
    run_op(0, X3, inv, zero, lat);
    chk("x3_inv", inv, X3I);

    run_op(0, '0, inv, zero, lat);
    chk("zero_skip_inv", inv, '0);
    chk("zero_skip_flag", {127'd0, zero}, 128'd1);
    chk("zero_skip_lat", 128'(lat), 128'd1);
    run_op(1, '0, inv, zero, lat);
    chk("zero_full_inv", inv, '0);
    chk("zero_full_flag", {127'd0, zero}, 128'd1);
    chk("zero_full_lat", 128'(lat), 128'd255);

    for (int k = 0; k < 4; k++) begin
      a = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
      run_op(0, a, inv, zero, lat);
      chk("rand_product", ref_mul(a, inv), ONE);
      chk("rand_zero", {127'd0, zero}, 128'd0);
      if (k < 2) begin
        run_op(1, inv, inv2, zero, lat);
        chk("rand_double_inv", inv2, a);
      end
    end

    // busy hold-off with in_valid held and in_a churning, then backpressure
    iv[0] = 1'b1;
    ia[0] = X1;
    @(posedge clk);
    #1;
    bad = 1'b0;
    n = 0;
    while (!ov[0] && n < 400) begin
      if (ir[0]) bad = 1'b1;
      ia[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_no_ready", {127'd0, bad}, 128'd0);
    chk("busy_result", oi[0], X1I);
    held = oi[0];
    bad  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (!ov[0] || oi[0] !== held || ir[0]) bad = 1'b1;
    end
    chk("bp_stable", {127'd0, bad}, 128'd0);
    ia[0]   = X2;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_ready_after", {127'd0, ir[0]}, 128'd1);
    chk("bp_valid_drop", {127'd0, ov[0]}, 128'd0);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("second_accepted", {127'd0, bz[0]}, 128'd1);
    n = 0;
    while (!ov[0] && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("second_result", oi[0], X2I);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;

    // asynchronous reset in the middle of an operation
    iv[0] = 1'b1;
    ia[0] = X3;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (99) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {127'd0, ir[0]}, 128'd1);
    chk("mid_rst_valid", {127'd0, ov[0]}, 128'd0);
    chk("mid_rst_busy",  {127'd0, bz[0]}, 128'd0);
    chk("mid_rst_inv",   oi[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(0, X1, inv, zero, lat);
    chk("post_rst_inv", inv, X1I);
    chk("post_rst_lat", 128'(lat), 128'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
